// File: rtl/interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// interval_timer_ctrl
//
// This is the programmable interval timer for the traffic-light datapath.
// It holds three interval registers: base, extended and yellow. The
// light-sequencing FSM requests a countdown with start_timer and
// interval_address. The block then counts that many whole seconds and
// raises a one-cycle "expired" pulse. A prescaler divides clk down to
// one-second ticks.
//
// Optional feature macro: IVT_REMAINING_EN
//   When defined, the "remaining" output shows the live countdown value.
//   When undefined, the port does not exist.
//
// Ports
//   clk               system clock; all state changes on the rising edge
//   sys_reset         asynchronous, active-low reset
//   start_timer       1 at an edge = load the selected interval, (re)start
//   interval_address  0 base, 1 ext, 2 yellow, 3 reserved (uses base)
//   prg_sync_in       pre-synchronized program strobe; a 0->1 edge writes
//   prg_sel           register to write (3 = ignored)
//   prg_value         value written to the selected register
//   expired           one-cycle pulse when the countdown reaches 0
//   busy              high while counting
//   remaining         seconds left (IVT_REMAINING_EN only)
// -----------------------------------------------------------------------------
module interval_timer_ctrl #(
  parameter int unsigned VAL_W    = 4,
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned T_BASE   = 6,
  parameter int unsigned T_EXT    = 3,
  parameter int unsigned T_YEL    = 2
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic             start_timer,
  input  logic [1:0]       interval_address,
  input  logic             prg_sync_in,
  input  logic [1:0]       prg_sel,
  input  logic [VAL_W-1:0] prg_value,
  output logic             expired,
  output logic             busy
`ifdef IVT_REMAINING_EN
  ,
  output logic [VAL_W-1:0] remaining
`endif
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [VAL_W-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             expired_q, expired_d;
  logic             prg_prev_q;
  logic [VAL_W-1:0] reg0_q, reg0_d;
  logic [VAL_W-1:0] reg1_q, reg1_d;
  logic [VAL_W-1:0] reg2_q, reg2_d;

  logic             prg_write;
  logic [VAL_W-1:0] load_val;

  assign prg_write = prg_sync_in & ~prg_prev_q;

  // Start reads the pre-write register contents. A write and a start in the
  // same cycle therefore loads the old value.
  always_comb begin
    load_val = reg0_q;
    case (interval_address)
      2'd1:    load_val = reg1_q;
      2'd2:    load_val = reg2_q;
      default: load_val = reg0_q;
    endcase
    if (load_val == '0) begin
      load_val = VAL_W'(1);
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
    reg0_d    = reg0_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;

    if (prg_write) begin
      case (prg_sel)
        2'd0:    reg0_d = prg_value;
        2'd1:    reg1_d = prg_value;
        2'd2:    reg2_d = prg_value;
        default: ;
      endcase
    end

    if (start_timer) begin
      // A restart wins over a tick or expiry in the same cycle.
      state_d = COUNT;
      count_d = load_val;
      presc_d = '0;
    end else if (state_q == COUNT) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        count_d = count_q - VAL_W'(1);
        if (count_q == VAL_W'(1)) begin
          state_d   = IDLE;
          expired_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      presc_q    <= '0;
      expired_q  <= 1'b0;
      prg_prev_q <= 1'b0;
      // NOTE: the interval registers are a small register file. They reset
      // because the controller must come up with usable default intervals.
      reg0_q     <= VAL_W'(T_BASE);
      reg1_q     <= VAL_W'(T_EXT);
      reg2_q     <= VAL_W'(T_YEL);
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      expired_q  <= expired_d;
      prg_prev_q <= prg_sync_in;
      reg0_q     <= reg0_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
    end
  end

  assign expired = expired_q;
  assign busy    = (state_q == COUNT);

`ifdef IVT_REMAINING_EN
  // count_q is already registered. It drops to 0 when the countdown
  // expires, so it reads 0 whenever the block is idle.
  assign remaining = count_q;
`endif

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Programmable interval timer controller for the traffic-light datapath. It holds the interval registers and sequences the countdown the light-sequencing FSM requests. The FSM drives `interval_address` and `start_timer`. This block loads the selected interval, counts whole seconds from a divided clock, and returns a single-cycle `expired`. Interval registers are rewritten from the synchronized program input `prg_sync_in`, with `prg_sel`/`prg_value`.

## Interface
- `VAL_W`, 4: width of interval registers and countdown, in seconds.
- `TICK_DIV`, 10: clk cycles per one-second tick; legal values are ≥2.
- `T_BASE`, 6: reset value of interval 0 (base).
- `T_EXT`, 3: reset value of interval 1 (extended).
- `T_YEL`, 2: reset value of interval 2 (yellow).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `sys_reset`  in  1  asynchronous, active-low reset.
- `start_timer`  in  1  level sampled each edge; 1 = load interval and start/restart countdown.
- `interval_address`  in  2  interval select, sampled with `start_timer`: 0 base, 1 ext, 2 yellow, 3 reserved (uses base).
- `prg_sync_in`  in  1  already-synchronized program strobe; a 0→1 edge triggers a write.
- `prg_sel`  in  2  register to write, sampled on the `prg_sync_in` rising edge; 3 is ignored.
- `prg_value`  in  VAL_W  value to write.
- `expired`  out  1  one-cycle pulse when the running interval reaches 0.
- `busy`  out  1  high while counting.
- `remaining`  out  VAL_W  seconds left; present only with `IVT_REMAINING_EN`.

## Operation
- **States.**
  - IDLE (`busy`=0) and COUNT (`busy`=1).
  - No other states; `expired` is a registered flag, not a state.
- **Interval registers.**
  - `reg0..reg2` reset to `T_BASE`, `T_EXT`, `T_YEL`.
- **Programming.**
  - An edge detector registers `prg_sync_in`; write when `prg_sync_in`=1 and its previous value was 0.
  - `reg[prg_sel]` ← `prg_value`.
  - A write never alters a countdown already in progress.
- **Start.**
  - `start_timer`=1 at an edge, in either state:
    - `count` ← `reg[interval_address]`;
    - prescaler ← 0;
    - state ← COUNT.
  - A loaded value of 0 is substituted by 1 (minimum interval one second).
- **Tick.**
  - The prescaler counts 0..TICK_DIV-1 in COUNT only; it holds at 0 in IDLE.
  - A tick occurs at the edge where prescaler = TICK_DIV-1.
- **Countdown.**
  - A tick in COUNT without `start_timer` decrements `count`.
  - When `count` goes 1→0: state ← IDLE and `expired` ← 1.
  - `expired` clears on the following edge.
- **Priority.** `start_timer` beats tick and expiry: a restart in the cycle where the final tick would occur reloads, and `expired` stays 0.
- **Simultaneous write and start on the same register:** the start loads the old value; the new value applies to the next start.
- **Reset mid-operation:**
  - state → IDLE, `count`=0, prescaler=0, `expired`=0;
  - registers → defaults;
  - edge-detector history → 0.

## Timing
- Reset values:
  - `expired`=0, `busy`=0, `remaining`=0;
  - registers = `T_BASE`/`T_EXT`/`T_YEL`.
- `start_timer` sampled at edge E0 → `busy`=1 after E0.
- `expired` is high during the cycle after edge E0 + N·`TICK_DIV`, where N is the loaded (non-zero) value; it lasts exactly one cycle.
- `busy` falls at the same edge `expired` rises.
- `start_timer` held high continuously restarts every cycle and never expires.
- Write latency: the register updates at the edge that samples the strobe's rising edge. It is usable by a start one cycle later.
- `remaining` is registered and equals `count`. It updates on the same edges.

## Configuration
- `IVT_REMAINING_EN` defined:
  - `remaining` port exists and shows `count`;
  - it is 0 in IDLE.
- Undefined:
  - the port and its register are removed;
  - all other behaviour is identical.

## Test plan
- Reset release, `interval_address`=0, 1-cycle start, `TICK_DIV`=10 → `expired` one cycle after edge E0+60; `busy` high 60 cycles.
- Address 2 then address 1 starts → `expired` after 20 and 30 cycles respectively; address 3 → 60.
- Program: rising edge with `prg_sel`=1, `prg_value`=5, then start on address 1 → expiry after 50 cycles. `prg_value`=0 → expiry after 10. `prg_sel`=3 → no register changes. `prg_sync_in` held high → single write.
- Restart: start address 0, second start at E0+55 with address 2 → no expired at E0+60; expired after E0+55+20.
- Same-cycle write `reg0`=9 and start address 0 → expiry after 60; next start → 90.
- `sys_reset` low mid-count at E0+30 → `busy`=0 and `expired`=0 immediately. No expiry follows. `reg1` returns to 3 even if previously programmed.
